stack_pointer_16: RTL and testbench
===================================

Name: stack_pointer_16

Overview:
- 16-bit hardware stack pointer for the RISC core. The stack grows downward.
- PUSH decrements SP and POP increments it.
- Each accepted operation produces a registered memory address plus a write or read strobe for the data memory port.
- Tracks fill level and raises sticky overflow/underflow errors.
- Sits beside the PC incrementor in the fetch/execute datapath and services CALL/RET/PUSH/POP.

Parameters:
- STACK_TOP, 16'hFFFF: address of the first (highest) stack slot; SP reset value.
- STACK_DEPTH, 256: maximum number of entries, legal range 1..65535.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  synchronous, active-low reset.
- PUSH  input  1  push request, one cycle per entry.
- POP  input  1  pop request, one cycle per entry.
- LD_EN  input  1  load SP from LD_VAL.
- LD_VAL  input  16  new SP value.
- CLR_ERR  input  1  clears OVF and UDF.
- SP  output  16  current stack pointer, the next free slot.
- MEM_ADDR  output  16  address for the strobed access, registered.
- MEM_WE  output  1  one-cycle write strobe, asserted for an accepted push.
- MEM_RE  output  1  one-cycle read strobe, asserted for an accepted pop.
- COUNT  output  16  entries in use, equal to STACK_TOP - SP.
- FULL  output  1  COUNT == STACK_DEPTH.
- EMPTY  output  1  COUNT == 0.
- OVF  output  1  sticky; a push was attempted while FULL.
- UDF  output  1  sticky; a pop was attempted while EMPTY.

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-low on RST_N, sampled on the rising edge of CLK.
- Reset values:
  - SP = STACK_TOP, COUNT = 0, EMPTY = 1, FULL = 0.
  - MEM_ADDR = 0, MEM_WE = 0, MEM_RE = 0, OVF = 0, UDF = 0.
- Reset overrides every request in the same cycle. Reset mid-operation drops any strobe that would have been generated.
- Priority per cycle: reset > LD_EN > PUSH/POP > idle.
- LD_EN:
  - SP <= LD_VAL; no strobe.
  - COUNT is recomputed from the new SP, mod 2^16.
  - PUSH/POP in the same cycle are ignored and do not set error flags.
  - If LD_VAL > STACK_TOP, COUNT wraps to a large value: EMPTY = 0, and FULL asserts only if COUNT equals STACK_DEPTH. No error flag is set; software owns this.
- Accepted PUSH (PUSH=1, POP=0, !FULL):
  - Next cycle: MEM_ADDR = old SP, MEM_WE = 1, SP = old SP - 1.
  - Latency 1 cycle.
- Accepted POP (POP=1, PUSH=0, !EMPTY):
  - Next cycle: MEM_ADDR = old SP + 1, MEM_RE = 1, SP = old SP + 1.
  - The data memory returns the read data in the cycle after MEM_RE; that path is outside this block.
- PUSH while FULL: SP unchanged, no strobe, OVF <= 1.
- POP while EMPTY: SP unchanged, no strobe, UDF <= 1.
- PUSH and POP together: no-op. SP held, no strobes, no error, even when FULL or EMPTY.
- Strobes:
  - MEM_WE and MEM_RE are never both 1 and each is high for exactly one cycle per accepted op.
  - Back-to-back ops every cycle are legal; MEM_ADDR updates each cycle.
  - MEM_ADDR holds its last value when no strobe is active.
- Arithmetic:
  - All arithmetic is 16-bit, modulo 2^16; borrow/carry-outs are discarded.
  - With STACK_TOP = 16'hFFFF, a POP from SP = FFFE yields MEM_ADDR = FFFF.
  - FULL/EMPTY are combinational from SP.
- Error flags:
  - CLR_ERR clears OVF/UDF next cycle.
  - If a new error occurs in the same cycle as CLR_ERR, the flag is set, not cleared (set wins).
- Internal state: the only architectural state is the SP register, the MEM_ADDR/strobe registers and the two flags. There are two control states: IDLE (no strobe) and ACCESS (strobe high one cycle), derived from the registered strobes.

Decomposition:
- Shared package constants:
  - STACK_TOP_DEFAULT = 16'hFFFF
  - STACK_DEPTH_DEFAULT = 256
  - 2-bit op encoding: OP_NONE = 0, OP_PUSH = 1, OP_POP = 2, OP_LOAD = 3, used by the decode/control logic.
- One natural sub-module, decrementor_16: a half-subtractor borrow-chain SP - 1 with a BOUT output. It is the mirror of the existing incrementor.
- The pop path reuses the existing incrementor for SP + 1. COUNT uses a 16-bit subtract against STACK_TOP.

Test Plan:
- Reset, then 3 PUSH cycles:
  - MEM_WE pulses at MEM_ADDR FFFF, FFFE, FFFD.
  - SP = FFFC, COUNT = 3.
- From there, 3 POP cycles:
  - MEM_RE pulses at MEM_ADDR FFFD, FFFE, FFFF.
  - SP = FFFF, EMPTY = 1.
- POP while EMPTY: no MEM_RE, SP = FFFF, UDF = 1. Then CLR_ERR → UDF = 0.
- 256 pushes → FULL = 1, SP = FEFF. A 257th push → no MEM_WE, OVF = 1, SP = FEFF.
- PUSH and POP asserted together at SP = FFF0: SP stays FFF0, no strobes, OVF = UDF = 0.
- LD_EN with LD_VAL = 1234 plus PUSH in the same cycle: SP = 1234, no MEM_WE. RST_N = 0 in the next cycle gives SP = FFFF and all flags/strobes 0.

Source files
------------

// File: rtl/stack_pointer_16_pkg.sv
// rtl/stack_pointer_16_pkg.sv - shared constants and op decode for the stack pointer
package stack_pointer_16_pkg;

  localparam logic [15:0] STACK_TOP_DEFAULT   = 16'hFFFF;
  localparam int          STACK_DEPTH_DEFAULT = 256;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_LOAD = 2'd3
  } sp_op_e;

  // Load beats push/pop; push and pop together collapse to a no-op.
  function automatic sp_op_e decode_op(input logic ld_en, input logic push, input logic pop);
    if (ld_en)              return OP_LOAD;
    else if (push && !pop)  return OP_PUSH;
    else if (pop && !push)  return OP_POP;
    else                    return OP_NONE;
  endfunction

endpackage

// File: rtl/decrementor_16.sv
// rtl/decrementor_16.sv - 16-bit half-subtractor borrow chain computing a - 1
module decrementor_16 (
  input  logic [15:0] a_i,
  output logic [15:0] d_o,
  output logic        bout_o
);

  logic [16:0] borrow;

  // Ripple a borrow from bit 0 upward; each stage is a half subtractor.
  always_comb begin
    borrow    = '0;
    d_o       = '0;
    borrow[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d_o[i]      = a_i[i] ^ borrow[i];
      borrow[i+1] = ~a_i[i] & borrow[i];
    end
    bout_o = borrow[16];
  end

endmodule

// File: rtl/stack_pointer_16.sv
// rtl/stack_pointer_16.sv - downward-growing stack pointer with memory strobes and sticky errors
module stack_pointer_16
  import stack_pointer_16_pkg::*;
#(
  parameter logic [15:0] STACK_TOP   = STACK_TOP_DEFAULT,
  parameter int          STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        PUSH,
  input  logic        POP,
  input  logic        LD_EN,
  input  logic [15:0] LD_VAL,
  input  logic        CLR_ERR,
  output logic [15:0] SP,
  output logic [15:0] MEM_ADDR,
  output logic        MEM_WE,
  output logic        MEM_RE,
  output logic [15:0] COUNT,
  output logic        FULL,
  output logic        EMPTY,
  output logic        OVF,
  output logic        UDF
);

  localparam logic [15:0] DEPTH16 = 16'(STACK_DEPTH);

  logic [15:0] sp_q, sp_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;

  logic [15:0] sp_dec;
  logic [15:0] sp_inc;
  logic        unused_bout;
  sp_op_e      op;

  // Borrow-out is dropped: arithmetic wraps modulo 2^16.
  decrementor_16 u_dec (
    .a_i    (sp_q),
    .d_o    (sp_dec),
    .bout_o (unused_bout)
  );

  assign sp_inc = sp_q + 16'd1;
  assign COUNT  = STACK_TOP - sp_q;
  assign FULL   = (COUNT == DEPTH16);
  assign EMPTY  = (COUNT == 16'd0);
  assign op     = decode_op(LD_EN, PUSH, POP);

  // Next-state decode: strobes default low, address holds, errors are set-wins over clear.
  always_comb begin
    sp_d   = sp_q;
    addr_d = addr_q;
    we_d   = 1'b0;
    re_d   = 1'b0;
    ovf_d  = ovf_q & ~CLR_ERR;
    udf_d  = udf_q & ~CLR_ERR;
    case (op)
      OP_LOAD: sp_d = LD_VAL;
      OP_PUSH: begin
        if (FULL) begin
          ovf_d = 1'b1;
        end else begin
          addr_d = sp_q;
          we_d   = 1'b1;
          sp_d   = sp_dec;
        end
      end
      OP_POP: begin
        if (EMPTY) begin
          udf_d = 1'b1;
        end else begin
          addr_d = sp_inc;
          re_d   = 1'b1;
          sp_d   = sp_inc;
        end
      end
      default: ;
    endcase
  end

  // State register; synchronous reset overrides any request in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sp_q   <= STACK_TOP;
      addr_q <= '0;
      we_q   <= 1'b0;
      re_q   <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      addr_q <= addr_d;
      we_q   <= we_d;
      re_q   <= re_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  assign SP       = sp_q;
  assign MEM_ADDR = addr_q;
  assign MEM_WE   = we_q;
  assign MEM_RE   = re_q;
  assign OVF      = ovf_q;
  assign UDF      = udf_q;

endmodule

// File: tb/tb_stack_pointer_16.sv
// tb/tb_stack_pointer_16.sv - directed self-checking bench for stack_pointer_16
module tb_stack_pointer_16;

  logic        CLK = 1'b0;
  logic        RST_N, PUSH, POP, LD_EN, CLR_ERR;
  logic [15:0] LD_VAL;
  logic [15:0] SP, MEM_ADDR, COUNT;
  logic        MEM_WE, MEM_RE, FULL, EMPTY, OVF, UDF;

  int n_vec = 0;
  int n_err = 0;

  stack_pointer_16 dut (
    .CLK(CLK), .RST_N(RST_N), .PUSH(PUSH), .POP(POP), .LD_EN(LD_EN),
    .LD_VAL(LD_VAL), .CLR_ERR(CLR_ERR), .SP(SP), .MEM_ADDR(MEM_ADDR),
    .MEM_WE(MEM_WE), .MEM_RE(MEM_RE), .COUNT(COUNT), .FULL(FULL),
    .EMPTY(EMPTY), .OVF(OVF), .UDF(UDF)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    RST_N = 1'b1; PUSH = 1'b0; POP = 1'b0; LD_EN = 1'b0; LD_VAL = 16'h0; CLR_ERR = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST_N = 1'b0;
    step();
    step();
    RST_N = 1'b1;
    n_vec++; if (SP !== 16'hFFFF) begin n_err++; $display("FAIL reset_sp got %h want FFFF", SP); end
    n_vec++; if (COUNT !== 16'h0000) begin n_err++; $display("FAIL reset_count got %h want 0000", COUNT); end
    n_vec++; if (EMPTY !== 1'b1 || FULL !== 1'b0) begin n_err++; $display("FAIL reset_empty_full got %b%b want 10", EMPTY, FULL); end
    n_vec++; if (MEM_ADDR !== 16'h0000) begin n_err++; $display("FAIL reset_addr got %h want 0000", MEM_ADDR); end
    n_vec++; if ({MEM_WE, MEM_RE, OVF, UDF} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b want 0000", {MEM_WE, MEM_RE, OVF, UDF}); end
  endtask

  task automatic test_push3();
    logic [15:0] exp_addr;
    for (int i = 0; i < 3; i++) begin
      PUSH = 1'b1;
      step();
      exp_addr = 16'hFFFF - 16'(i);
      n_vec++; if (MEM_WE !== 1'b1 || MEM_RE !== 1'b0) begin n_err++; $display("FAIL push3_strobe[%0d] got we=%b re=%b want we=1 re=0", i, MEM_WE, MEM_RE); end
      n_vec++; if (MEM_ADDR !== exp_addr) begin n_err++; $display("FAIL push3_addr[%0d] got %h want %h", i, MEM_ADDR, exp_addr); end
    end
    PUSH = 1'b0;
    step();
    n_vec++; if (MEM_WE !== 1'b0) begin n_err++; $display("FAIL push3_we_drop got %b want 0", MEM_WE); end
    n_vec++; if (MEM_ADDR !== 16'hFFFD) begin n_err++; $display("FAIL push3_addr_hold got %h want FFFD", MEM_ADDR); end
    n_vec++; if (SP !== 16'hFFFC) begin n_err++; $display("FAIL push3_sp got %h want FFFC", SP); end
    n_vec++; if (COUNT !== 16'd3) begin n_err++; $display("FAIL push3_count got %h want 0003", COUNT); end
  endtask

  task automatic test_pop3();
    logic [15:0] exp_addr;
    for (int i = 0; i < 3; i++) begin
      POP = 1'b1;
      step();
      exp_addr = 16'hFFFD + 16'(i);
      n_vec++; if (MEM_RE !== 1'b1 || MEM_WE !== 1'b0) begin n_err++; $display("FAIL pop3_strobe[%0d] got re=%b we=%b want re=1 we=0", i, MEM_RE, MEM_WE); end
      n_vec++; if (MEM_ADDR !== exp_addr) begin n_err++; $display("FAIL pop3_addr[%0d] got %h want %h", i, MEM_ADDR, exp_addr); end
    end
    POP = 1'b0;
    step();
    n_vec++; if (MEM_RE !== 1'b0) begin n_err++; $display("FAIL pop3_re_drop got %b want 0", MEM_RE); end
    n_vec++; if (SP !== 16'hFFFF) begin n_err++; $display("FAIL pop3_sp got %h want FFFF", SP); end
    n_vec++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL pop3_empty got %b want 1", EMPTY); end
  endtask

  task automatic test_underflow();
    POP = 1'b1;
    step();
    POP = 1'b0;
    n_vec++; if (MEM_RE !== 1'b0) begin n_err++; $display("FAIL udf_re got %b want 0", MEM_RE); end
    n_vec++; if (SP !== 16'hFFFF) begin n_err++; $display("FAIL udf_sp got %h want FFFF", SP); end
    n_vec++; if (UDF !== 1'b1 || OVF !== 1'b0) begin n_err++; $display("FAIL udf_set got udf=%b ovf=%b want udf=1 ovf=0", UDF, OVF); end
    step();
    n_vec++; if (UDF !== 1'b1) begin n_err++; $display("FAIL udf_sticky got %b want 1", UDF); end
    CLR_ERR = 1'b1;
    step();
    CLR_ERR = 1'b0;
    n_vec++; if (UDF !== 1'b0) begin n_err++; $display("FAIL udf_clear got %b want 0", UDF); end
  endtask

  task automatic test_full_overflow();
    logic [15:0] exp_addr;
    for (int i = 0; i < 256; i++) begin
      PUSH = 1'b1;
      step();
      exp_addr = 16'hFFFF - 16'(i);
      n_vec++; if (MEM_WE !== 1'b1 || MEM_ADDR !== exp_addr) begin n_err++; $display("FAIL fill_push[%0d] got we=%b addr=%h want we=1 addr=%h", i, MEM_WE, MEM_ADDR, exp_addr); end
    end
    PUSH = 1'b0;
    step();
    n_vec++; if (FULL !== 1'b1 || EMPTY !== 1'b0) begin n_err++; $display("FAIL fill_full got full=%b empty=%b want 1 0", FULL, EMPTY); end
    n_vec++; if (SP !== 16'hFEFF) begin n_err++; $display("FAIL fill_sp got %h want FEFF", SP); end
    n_vec++; if (COUNT !== 16'd256) begin n_err++; $display("FAIL fill_count got %h want 0100", COUNT); end
    PUSH = 1'b1;
    step();
    PUSH = 1'b0;
    n_vec++; if (MEM_WE !== 1'b0) begin n_err++; $display("FAIL ovf_we got %b want 0", MEM_WE); end
    n_vec++; if (OVF !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", OVF); end
    n_vec++; if (SP !== 16'hFEFF) begin n_err++; $display("FAIL ovf_sp got %h want FEFF", SP); end
    // A new overflow in the same cycle as a clear keeps the flag set.
    PUSH = 1'b1; CLR_ERR = 1'b1;
    step();
    PUSH = 1'b0;
    n_vec++; if (OVF !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins got %b want 1", OVF); end
    step();
    CLR_ERR = 1'b0;
    n_vec++; if (OVF !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", OVF); end
    POP = 1'b1;
    step();
    POP = 1'b0;
    n_vec++; if (MEM_RE !== 1'b1 || MEM_ADDR !== 16'hFF00 || SP !== 16'hFF00) begin n_err++; $display("FAIL pop_from_full got re=%b addr=%h sp=%h want 1 FF00 FF00", MEM_RE, MEM_ADDR, SP); end
  endtask

  task automatic test_push_pop_together();
    LD_EN = 1'b1; LD_VAL = 16'hFFF0;
    step();
    LD_EN = 1'b0;
    n_vec++; if (SP !== 16'hFFF0 || COUNT !== 16'h000F) begin n_err++; $display("FAIL both_load got sp=%h count=%h want FFF0 000F", SP, COUNT); end
    PUSH = 1'b1; POP = 1'b1;
    step();
    n_vec++; if (SP !== 16'hFFF0) begin n_err++; $display("FAIL both_sp got %h want FFF0", SP); end
    n_vec++; if ({MEM_WE, MEM_RE, OVF, UDF} !== 4'b0000) begin n_err++; $display("FAIL both_flags got %b want 0000", {MEM_WE, MEM_RE, OVF, UDF}); end
    // Same no-op when the stack is empty: no underflow.
    PUSH = 1'b0; POP = 1'b0; LD_EN = 1'b1; LD_VAL = 16'hFFFF;
    step();
    LD_EN = 1'b0; PUSH = 1'b1; POP = 1'b1;
    step();
    PUSH = 1'b0; POP = 1'b0;
    n_vec++; if (SP !== 16'hFFFF || {MEM_WE, MEM_RE, OVF, UDF} !== 4'b0000) begin n_err++; $display("FAIL both_empty got sp=%h flags=%b want FFFF 0000", SP, {MEM_WE, MEM_RE, OVF, UDF}); end
  endtask

  task automatic test_load_then_reset();
    LD_EN = 1'b1; LD_VAL = 16'h1234; PUSH = 1'b1;
    step();
    LD_EN = 1'b0;
    n_vec++; if (SP !== 16'h1234) begin n_err++; $display("FAIL load_sp got %h want 1234", SP); end
    n_vec++; if (MEM_WE !== 1'b0 || OVF !== 1'b0) begin n_err++; $display("FAIL load_no_strobe got we=%b ovf=%b want 0 0", MEM_WE, OVF); end
    n_vec++; if (COUNT !== 16'hEDCB || EMPTY !== 1'b0 || FULL !== 1'b0) begin n_err++; $display("FAIL load_count got %h e=%b f=%b want EDCB 0 0", COUNT, EMPTY, FULL); end
    // Push still requested while reset asserts: the strobe must be dropped.
    RST_N = 1'b0;
    step();
    RST_N = 1'b1; PUSH = 1'b0;
    n_vec++; if (SP !== 16'hFFFF) begin n_err++; $display("FAIL rst_sp got %h want FFFF", SP); end
    n_vec++; if ({MEM_WE, MEM_RE, OVF, UDF} !== 4'b0000 || MEM_ADDR !== 16'h0000) begin n_err++; $display("FAIL rst_flags got %b addr=%h want 0000 0000", {MEM_WE, MEM_RE, OVF, UDF}, MEM_ADDR); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_push3();
    test_pop3();
    test_underflow();
    test_full_overflow();
    test_push_pop_together();
    test_load_then_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
